// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM state
// encoding and the bit positions of the STATUS register.
package mmio_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int unsigned STAT_FULL  = 0;
    localparam int unsigned STAT_EMPTY = 1;
    localparam int unsigned STAT_BUSY  = 2;
    localparam int unsigned STAT_OVF   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign do_pop   = pop && !empty;
    // Freeing a slot this cycle makes room for a simultaneous push.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA store pushes a byte into a FIFO,
// STATUS load returns {overflow, busy, empty, full}; 8N1 serialiser.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_write_en,
    input  logic [31:0] memory_write_address,
    input  logic [31:0] memory_write,
    input  logic [31:0] memory_read_address,
    output logic [31:0] memory_read_data,
    output logic        uart_tx
);

    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [15:0] BAUD_LAST   = 16'(CLKS_PER_BIT - 1);

    uart_tx_state_t state;
    logic [15:0]    baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           tx_q;
    logic           overflow;

    logic           push;
    logic           pop;
    logic           ovf_clr;
    logic           baud_end;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_dout;
    logic [3:0]     status;
    logic           unused_wdata;

    assign unused_wdata = ^memory_write[31:8];

    assign push     = memory_write_en && (memory_write_address == BASE_ADDR);
    assign ovf_clr  = memory_write_en && (memory_write_address == STATUS_ADDR) && memory_write[3];
    assign baud_end = (baud_cnt == BAUD_LAST);
    // Popping at the end of STOP lets the next frame follow with no idle gap.
    assign pop      = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_end));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (memory_write[7:0]),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // STATUS register assembly.
    always_comb begin
        status            = '0;
        status[STAT_FULL]  = fifo_full;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_BUSY]  = (state != IDLE);
        status[STAT_OVF]   = overflow;
    end

    // Sticky overflow: set by a dropped push, cleared by software.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // Registered load data, one cycle after the address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memory_read_data <= '0;
        end else if (memory_read_address == STATUS_ADDR) begin
            memory_read_data <= {28'b0, status};
        end else begin
            memory_read_data <= '0;
        end
    end

    // Transmit FSM with registered serial output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_q     <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shreg <= fifo_dout;
                        state <= START;
                        tx_q  <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx_q     <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            shreg <= {1'b0, shreg[7:1]};
                            tx_q  <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shreg <= fifo_dout;
                            state <= START;
                            tx_q  <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx_q  <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

    assign uart_tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with a 4-clock bit time and 4-deep FIFO.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] STAT = 32'h0000_1004;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic        uart_tx;

    mmio_uart_tx #(
        .BASE_ADDR    (32'h0000_1000),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .memory_write_en      (we),
        .memory_write_address (waddr),
        .memory_write         (wdata),
        .memory_read_address  (raddr),
        .memory_read_data     (rdata),
        .uart_tx              (uart_tx)
    );

    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Independent serial receiver: samples mid-bit, records bytes and start cycles.
    int unsigned cyc = 0;
    int unsigned rx_cnt = 0;
    int unsigned rx_bad = 0;
    bit          rx_active = 1'b0;
    logic [7:0]  rx_sh = '0;
    logic [7:0]  rx_q[$];
    int unsigned rx_start_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (uart_tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
                rx_start_q.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == 2 && uart_tx !== 1'b0) rx_bad++;
            if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 6) % 4) == 0)
                rx_sh[(rx_cnt - 6) / 4] = uart_tx;
            if (rx_cnt == 38 && uart_tx !== 1'b1) rx_bad++;
            if (rx_cnt == 39) begin
                rx_q.push_back(rx_sh);
                rx_active = 1'b0;
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic wait_frames(input int unsigned n, input int unsigned budget);
        int unsigned k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frame_count", rx_q.size(), n);
    endtask

    task automatic check_seq(input logic [7:0] first, input int unsigned n);
        logic [7:0] e;
        for (int unsigned i = 0; i < n && i < rx_q.size(); i++) begin
            e = first + 8'(i);
            check($sformatf("frame%0d_byte", i), {24'b0, rx_q[i]}, {24'b0, e});
            if (i > 0 && i < rx_start_q.size())
                check($sformatf("frame%0d_gap", i), rx_start_q[i] - rx_start_q[i-1], 40);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        logic       exp_tx;

        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = STAT;

        // Register-decode vectors applied from idle; none may start a frame.
        vecs[0] = '{1'b0, 32'h0,          32'h0,          STAT,           32'h2};
        vecs[1] = '{1'b1, 32'h0000_1008,  32'h0000_0041,  BASE,           32'h0};
        vecs[2] = '{1'b0, 32'h0,          32'h0,          STAT,           32'h2};
        vecs[3] = '{1'b1, STAT,           32'hFFFF_FFFF,  STAT,           32'h2};
        vecs[4] = '{1'b1, 32'h0000_0FFC,  32'h0000_0012,  32'h0000_1008,  32'h0};
        vecs[5] = '{1'b0, 32'h0,          32'h0,          STAT,           32'h2};
        vecs[6] = '{1'b0, 32'h0,          32'h0,          32'h0,          32'h0};
        vecs[7] = '{1'b0, 32'h0,          32'h0,          32'h0000_1005,  32'h0};

        repeat (3) @(negedge clk);
        check("reset_tx", {31'b0, uart_tx}, 32'h1);
        check("reset_rdata", rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("status_after_reset", rdata, 32'h2);

        for (int i = 0; i < 8; i++) begin
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata; raddr = vecs[i].raddr;
            @(negedge clk);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_tx", i), {31'b0, uart_tx}, 32'h1);
        end
        we = 1'b0; raddr = STAT;
        repeat (50) @(negedge clk);
        check("no_frame_from_bad_addr", rx_start_q.size(), 0);

        // Single frame, bit-exact timing.
        rx_q.delete(); rx_start_q.delete();
        b = 8'h55;
        store(BASE, 32'hFFFF_FF55);
        for (int unsigned n = 1; n <= 41; n++) begin
            @(negedge clk);
            if (n <= 4)       exp_tx = 1'b0;
            else if (n <= 36) exp_tx = b[(n - 5) / 4];
            else              exp_tx = 1'b1;
            check($sformatf("f55_tx_c%0d", n), {31'b0, uart_tx}, {31'b0, exp_tx});
            if (n == 41) check("f55_status_busy", rdata, 32'h6);
        end
        @(negedge clk);
        check("f55_status_idle", rdata, 32'h2);
        check("f55_frames", rx_q.size(), 1);
        check_seq(8'h55, 1);

        // Six back-to-back stores into a 4-deep FIFO: last one dropped.
        rx_q.delete(); rx_start_q.delete();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            we = 1'b1; waddr = BASE; wdata = 32'(i);
        end
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
        check("overflow_status", rdata, 32'hD);
        wait_frames(5, 400);
        check_seq(8'h01, 5);
        repeat (60) @(negedge clk);
        check("no_sixth_frame", rx_q.size(), 5);
        check("ovf_sticky_idle", rdata, 32'hA);

        // Overflow clear only with bit 3 set.
        store(STAT, 32'hFFFF_FFF7);
        @(negedge clk);
        check("ovf_not_cleared", rdata, 32'hA);
        store(STAT, 32'h0000_0008);
        @(negedge clk);
        check("ovf_cleared", rdata, 32'h2);

        // Reset mid-frame.
        rx_q.delete(); rx_start_q.delete();
        store(BASE, 32'h0000_00A5);
        repeat (10) @(negedge clk);
        check("midframe_tx_low", {31'b0, uart_tx}, 32'h0);
        reset = 1'b1;
        #1;
        check("async_reset_tx", {31'b0, uart_tx}, 32'h1);
        check("async_reset_rdata", rdata, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rx_q.delete(); rx_start_q.delete();
        @(negedge clk);
        check("status_after_midreset", rdata, 32'h2);
        repeat (80) @(negedge clk);
        check("no_frame_after_reset", rx_start_q.size(), 0);
        check("idle_tx_after_reset", {31'b0, uart_tx}, 32'h1);

        // FIFO full, push lands on the edge that ends a frame.
        rx_q.delete(); rx_start_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            we = 1'b1; waddr = BASE; wdata = 32'h11 + 32'(i);
        end
        @(negedge clk);
        we = 1'b0;
        repeat (36) @(negedge clk);
        we = 1'b1; waddr = BASE; wdata = 32'h16;
        @(negedge clk);
        we = 1'b0;
        check("full_before_edge", rdata, 32'h5);
        @(negedge clk);
        check("full_push_pop_no_ovf", rdata, 32'h5);
        wait_frames(6, 400);
        check_seq(8'h11, 6);
        repeat (5) @(negedge clk);
        check("final_status", rdata, 32'h2);
        check("rx_framing_errors", rx_bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
